// File: rtl/controle_envase.sv
`default_nettype none
// ============================================================================
// Module      : controle_envase
// Description : Bottling-line sequencer: conveyor, fill, cap, count by dozen.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_envase #(
  parameter logic [15:0] T_VEDACAO = 16'd50000,
  parameter logic [27:0] T_ENCHE   = 28'd150000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       sensor_posicao,
  input  logic       sensor_nivel,
  input  logic       sensor_vedacao,
  input  logic       sensor_final,
  input  logic       rejeito,
  input  logic       rolhas_vazio,
  output logic       motor_esteira,
  output logic       valvula,
  output logic       vedador,
  output logic       descarte,
  output logic       incrementar_duzia,
  output logic       reset_contador,
  output logic [3:0] garrafas_parcial,
  output logic [2:0] estado,
  output logic       alarme
);

  typedef enum logic [2:0] {
    PARADO        = 3'd0,
    ESTEIRA       = 3'd1,
    ENCHENDO      = 3'd2,
    ESTEIRA_VEDA  = 3'd3,
    VEDANDO       = 3'd4,
    ESTEIRA_FINAL = 3'd5,
    ALARME        = 3'd6
  } estado_t;

  localparam logic [27:0] c_ved_last   = {12'd0, T_VEDACAO} - 28'd1;
  localparam logic [27:0] c_enche_last = T_ENCHE - 28'd1;

  estado_t     r_estado;
  estado_t     w_next;
  logic [27:0] r_timer;
  logic [3:0]  r_garr;
  logic [3:0]  w_garr;
  logic        r_pos_q;
  logic        r_ved_q;
  logic        r_fin_q;
  logic        r_descarte;
  logic        r_inc;
  logic        r_rstc;
  logic        w_descarte;
  logic        w_inc;
  logic        w_rstc;
  logic        w_rise_pos;
  logic        w_rise_ved;
  logic        w_rise_fin;

  assign w_rise_pos = sensor_posicao & ~r_pos_q;
  assign w_rise_ved = sensor_vedacao & ~r_ved_q;
  assign w_rise_fin = sensor_final   & ~r_fin_q;

  always_comb begin
    w_next     = r_estado;
    w_garr     = r_garr;
    w_descarte = 1'b0;
    w_inc      = 1'b0;
    w_rstc     = 1'b0;
    if (stop) begin
      w_next = PARADO;
    end else begin
      case (r_estado)
        PARADO: begin
          if (start) begin
            w_next = ESTEIRA;
            w_garr = 4'd0;
            w_rstc = 1'b1;
          end
        end
        ESTEIRA: begin
          if (w_rise_pos) w_next = ENCHENDO;
        end
        ENCHENDO: begin
          if (sensor_nivel)                   w_next = ESTEIRA_VEDA;
          else if (r_timer == c_enche_last)   w_next = ALARME;
        end
        ESTEIRA_VEDA: begin
          if (w_rise_ved) w_next = rolhas_vazio ? ALARME : VEDANDO;
        end
        VEDANDO: begin
          // rejeito only matters on the final capping cycle
          if (r_timer == c_ved_last) begin
            if (rejeito) begin
              w_next     = ESTEIRA;
              w_descarte = 1'b1;
            end else begin
              w_next = ESTEIRA_FINAL;
            end
          end
        end
        ESTEIRA_FINAL: begin
          if (w_rise_fin) begin
            w_next = ESTEIRA;
            if (r_garr == 4'd11) begin
              w_garr = 4'd0;
              w_inc  = 1'b1;
            end else begin
              w_garr = r_garr + 4'd1;
            end
          end
        end
        ALARME: begin
          if (start && !rolhas_vazio) begin
            w_next = ESTEIRA;
            w_garr = 4'd0;
            w_rstc = 1'b1;
          end
        end
        default: w_next = PARADO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado   <= PARADO;
      r_timer    <= 28'd0;
      r_garr     <= 4'd0;
      r_pos_q    <= 1'b0;
      r_ved_q    <= 1'b0;
      r_fin_q    <= 1'b0;
      r_descarte <= 1'b0;
      r_inc      <= 1'b0;
      r_rstc     <= 1'b0;
    end else begin
      r_estado   <= w_next;
      r_garr     <= w_garr;
      r_pos_q    <= sensor_posicao;
      r_ved_q    <= sensor_vedacao;
      r_fin_q    <= sensor_final;
      r_descarte <= w_descarte;
      r_inc      <= w_inc;
      r_rstc     <= w_rstc;
      if (w_next != r_estado)
        r_timer <= 28'd0;
      else if (r_estado == ENCHENDO || r_estado == VEDANDO)
        r_timer <= r_timer + 28'd1;
    end
  end

  assign motor_esteira     = (r_estado == ESTEIRA) || (r_estado == ESTEIRA_VEDA) ||
                             (r_estado == ESTEIRA_FINAL);
  assign valvula           = (r_estado == ENCHENDO);
  assign vedador           = (r_estado == VEDANDO);
  assign alarme            = (r_estado == ALARME);
  assign descarte          = r_descarte;
  assign incrementar_duzia = r_inc;
  assign reset_contador    = r_rstc;
  assign garrafas_parcial  = r_garr;
  assign estado            = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controle_envase.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_envase
// Description : Directed vector table plus timing sequences for controle_envase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_envase;

  localparam logic [7:0] I_START = 8'h80;
  localparam logic [7:0] I_STOP  = 8'h40;
  localparam logic [7:0] I_POS   = 8'h20;
  localparam logic [7:0] I_NIV   = 8'h10;
  localparam logic [7:0] I_VED   = 8'h08;
  localparam logic [7:0] I_FIN   = 8'h04;
  localparam logic [7:0] I_REJ   = 8'h02;
  localparam logic [7:0] I_ROL   = 8'h01;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic       sensor_posicao = 1'b0, sensor_nivel = 1'b0;
  logic       sensor_vedacao = 1'b0, sensor_final = 1'b0;
  logic       rejeito = 1'b0, rolhas_vazio = 1'b0;
  logic       motor_esteira, valvula, vedador, descarte;
  logic       incrementar_duzia, reset_contador, alarme;
  logic [3:0] garrafas_parcial;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  controle_envase #(.T_VEDACAO(16'd4), .T_ENCHE(28'd20)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .stop              (stop),
    .sensor_posicao    (sensor_posicao),
    .sensor_nivel      (sensor_nivel),
    .sensor_vedacao    (sensor_vedacao),
    .sensor_final      (sensor_final),
    .rejeito           (rejeito),
    .rolhas_vazio      (rolhas_vazio),
    .motor_esteira     (motor_esteira),
    .valvula           (valvula),
    .vedador           (vedador),
    .descarte          (descarte),
    .incrementar_duzia (incrementar_duzia),
    .reset_contador    (reset_contador),
    .garrafas_parcial  (garrafas_parcial),
    .estado            (estado),
    .alarme            (alarme)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [7:0]  in;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected output word {estado, motor, valvula, vedador, descarte, inc, rstc, alarme, garr}
  function automatic logic [13:0] ex(input logic [2:0] st, input logic [3:0] g,
                                     input logic d, input logic i, input logic r);
    logic mo;
    mo = (st == 3'd1) || (st == 3'd3) || (st == 3'd5);
    return {st, mo, st == 3'd2, st == 3'd4, d, i, r, st == 3'd6, g};
  endfunction

  function automatic logic [13:0] cur();
    return {estado, motor_esteira, valvula, vedador, descarte,
            incrementar_duzia, reset_contador, alarme, garrafas_parcial};
  endfunction

  task automatic add(input string nm, input logic [7:0] in, input logic [13:0] e);
    vec_t v;
    v.nm  = nm;
    v.in  = in;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic [7:0] v);
    {start, stop, sensor_posicao, sensor_nivel,
     sensor_vedacao, sensor_final, rejeito, rolhas_vazio} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // One nominal bottle from ESTEIRA; reports capper cycles and dozen pulses seen
  task automatic run_bottle(output int ved_cycles, output int inc_seen, output logic inc_last);
    logic [7:0] steps [8];
    steps = '{I_POS, I_NIV, I_VED, 8'h00, 8'h00, 8'h00, 8'h00, I_FIN};
    ved_cycles = 0;
    inc_seen   = 0;
    inc_last   = 1'b0;
    for (int s = 0; s < 8; s++) begin
      set_in(steps[s]);
      tick();
      if (vedador)           ved_cycles++;
      if (incrementar_duzia) inc_seen++;
      inc_last = incrementar_duzia;
    end
    set_in(8'h00);
  endtask

  initial begin
    int         cnt;
    int         vc;
    int         ic;
    logic       il;
    logic [3:0] g_exp;

    // nominal bottle, rejeito high on non-final capping cycles must be ignored
    add("idle_after_rst", 8'h00,   ex(3'd0, 4'd0, 0, 0, 0));
    add("start",          I_START, ex(3'd1, 4'd0, 0, 0, 1));
    add("est_idle",       8'h00,   ex(3'd1, 4'd0, 0, 0, 0));
    add("pos_rise",       I_POS,   ex(3'd2, 4'd0, 0, 0, 0));
    add("nivel",          I_NIV,   ex(3'd3, 4'd0, 0, 0, 0));
    add("ved_rise",       I_VED,   ex(3'd4, 4'd0, 0, 0, 0));
    add("ved_c1",         I_REJ,   ex(3'd4, 4'd0, 0, 0, 0));
    add("ved_c2",         I_REJ,   ex(3'd4, 4'd0, 0, 0, 0));
    add("ved_c3",         I_REJ,   ex(3'd4, 4'd0, 0, 0, 0));
    add("ved_last_ok",    8'h00,   ex(3'd5, 4'd0, 0, 0, 0));
    add("fin_rise",       I_FIN,   ex(3'd1, 4'd1, 0, 0, 0));
    add("nom_hold",       8'h00,   ex(3'd1, 4'd1, 0, 0, 0));
    // reject on last capping cycle
    add("rj_pos",         I_POS,   ex(3'd2, 4'd1, 0, 0, 0));
    add("rj_niv",         I_NIV,   ex(3'd3, 4'd1, 0, 0, 0));
    add("rj_ved",         I_VED,   ex(3'd4, 4'd1, 0, 0, 0));
    add("rj_w1",          8'h00,   ex(3'd4, 4'd1, 0, 0, 0));
    add("rj_w2",          8'h00,   ex(3'd4, 4'd1, 0, 0, 0));
    add("rj_w3",          8'h00,   ex(3'd4, 4'd1, 0, 0, 0));
    add("rj_last",        I_REJ,   ex(3'd1, 4'd1, 1, 0, 0));
    add("rj_after",       8'h00,   ex(3'd1, 4'd1, 0, 0, 0));
    // edges in states that do not consume them
    add("ign_fin",        I_FIN,   ex(3'd1, 4'd1, 0, 0, 0));
    add("ign_ved",        I_VED,   ex(3'd1, 4'd1, 0, 0, 0));
    add("ign_clr",        8'h00,   ex(3'd1, 4'd1, 0, 0, 0));
    // stop priority, count held
    add("st_pos",         I_POS,           ex(3'd2, 4'd1, 0, 0, 0));
    add("st_stop_start",  I_STOP | I_START, ex(3'd0, 4'd1, 0, 0, 0));
    add("st_parado_both", I_STOP | I_START, ex(3'd0, 4'd1, 0, 0, 0));
    add("st_restart",     I_START,          ex(3'd1, 4'd0, 0, 0, 1));
    // caps empty
    add("cp_pos",         I_POS,           ex(3'd2, 4'd0, 0, 0, 0));
    add("cp_niv",         I_NIV,           ex(3'd3, 4'd0, 0, 0, 0));
    add("cp_ved_empty",   I_VED | I_ROL,   ex(3'd6, 4'd0, 0, 0, 0));
    add("cp_start_empty", I_START | I_ROL, ex(3'd6, 4'd0, 0, 0, 0));
    add("cp_start_ok",    I_START,         ex(3'd1, 4'd0, 0, 0, 1));
    add("cp_hold",        8'h00,           ex(3'd1, 4'd0, 0, 0, 0));

    set_in(8'h00);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(cur()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      set_in(tbl[k].in);
      tick();
      chk(tbl[k].nm, 32'(cur()), 32'(tbl[k].exp));
    end
    set_in(8'h00);

    // fill timeout: 20 cycles in ENCHENDO then ALARME
    set_in(I_POS);
    tick();
    chk("to_enter", 32'(estado), 32'd2);
    set_in(8'h00);
    cnt = 0;
    for (int k = 0; k < 19; k++) begin
      tick();
      if (estado == 3'd2 && valvula) cnt++;
    end
    chk("to_fill_cycles", 32'(cnt), 32'd19);
    tick();
    chk("to_alarm", 32'(cur()), 32'(ex(3'd6, 4'd0, 0, 0, 0)));
    set_in(I_START);
    tick();
    chk("to_recover", 32'(cur()), 32'(ex(3'd1, 4'd0, 0, 0, 1)));
    set_in(8'h00);

    // dozen: 13 bottles
    for (int b = 1; b <= 13; b++) begin
      run_bottle(vc, ic, il);
      g_exp = 4'(b % 12);
      chk($sformatf("dz_state_%0d", b), 32'(estado), 32'd1);
      chk($sformatf("dz_garr_%0d", b), 32'(garrafas_parcial), 32'(g_exp));
      chk($sformatf("dz_inc_cnt_%0d", b), 32'(ic), (b == 12) ? 32'd1 : 32'd0);
      chk($sformatf("dz_inc_last_%0d", b), 32'(il), (b == 12) ? 32'd1 : 32'd0);
      if (b == 1) chk("dz_ved_cycles", 32'(vc), 32'd4);
    end

    // asynchronous reset while capping
    set_in(I_POS); tick();
    set_in(I_NIV); tick();
    set_in(I_VED); tick();
    set_in(8'h00);
    chk("rs_in_vedando", 32'(vedador), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_async_clear", 32'(cur()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rs_first_clk", 32'(cur()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controle_envase.md
CONTROLE_ENVASE -- requirements
Module: controle_envase

Interface
REQ-001 Parameter T_VEDACAO, default 16'd50000, capper-active duration in clk cycles (1 ms at 50 MHz).
REQ-002 Parameter T_ENCHE, default 28'd150000000, fill timeout in clk cycles (3 s).
REQ-003 clk  input  1  system clock, 50 MHz; one clock domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  synchronous one-cycle pulse from the debounced KEY0.
REQ-006 stop  input  1  synchronous one-cycle pulse, halt request.
REQ-007 sensor_posicao  input  1  level, bottle under fill nozzle.
REQ-008 sensor_nivel  input  1  level, fill level reached.
REQ-009 sensor_vedacao  input  1  level, bottle under capper.
REQ-010 sensor_final  input  1  level, bottle at end of line.
REQ-011 rejeito  input  1  level, quality check failed.
REQ-012 rolhas_vazio  input  1  level, cap stock empty.
REQ-013 motor_esteira  output  1  conveyor motor on.
REQ-014 valvula  output  1  fill valve open.
REQ-015 vedador  output  1  capper active.
REQ-016 descarte  output  1  one-cycle reject-ejector pulse.
REQ-017 incrementar_duzia  output  1  one-cycle pulse, one dozen completed; drives the dozen counter increment.
REQ-018 reset_contador  output  1  one-cycle pulse; drives the dozen counter manual reset.
REQ-019 garrafas_parcial  output  4  approved bottles in the current dozen, range 0-11.
REQ-020 estado  output  3  current state encoding.
REQ-021 alarme  output  1  fault indication.

Function
REQ-022 States and encoding: PARADO=0, ESTEIRA=1, ENCHENDO=2, ESTEIRA_VEDA=3, VEDANDO=4, ESTEIRA_FINAL=5, ALARME=6; code 7 unreachable and decodes to PARADO on the next clk.
REQ-023 All four sensors are edge-detected internally (registered previous value); "rise" means 1 now and 0 last cycle.
REQ-024 motor_esteira, valvula, vedador and alarme are decoded from the state register only, with no combinational input-to-output path.
REQ-025 Output decode:
  - motor_esteira=1 in ESTEIRA, ESTEIRA_VEDA and ESTEIRA_FINAL.
  - valvula=1 in ENCHENDO.
  - vedador=1 in VEDANDO.
  - alarme=1 in ALARME.
REQ-026 PARADO: on start, go to ESTEIRA, clear garrafas_parcial to 0 and pulse reset_contador for 1 cycle.
REQ-027 ESTEIRA: on rise of sensor_posicao, go to ENCHENDO and clear the timer.
REQ-028 ENCHENDO: timer increments each cycle.
  - sensor_nivel=1: go to ESTEIRA_VEDA.
  - Else, timer reaches T_ENCHE-1: go to ALARME.
REQ-029 ESTEIRA_VEDA: on rise of sensor_vedacao, go to ALARME if rolhas_vazio=1, otherwise go to VEDANDO and clear the timer.
REQ-030 VEDANDO lasts exactly T_VEDACAO cycles. On its last cycle, rejeito is sampled:
  - rejeito=1: pulse descarte and go to ESTEIRA; garrafas_parcial is unchanged.
  - rejeito=0: go to ESTEIRA_FINAL.
REQ-031 ESTEIRA_FINAL: on rise of sensor_final, go to ESTEIRA and update the count:
  - garrafas_parcial<11: increment it.
  - garrafas_parcial=11: set it to 0 and pulse incrementar_duzia in the same cycle.
REQ-032 ALARME: on start, go to ESTEIRA and pulse reset_contador, but only if rolhas_vazio=0; otherwise stay in ALARME; garrafas_parcial is cleared on exit.
REQ-033 stop in any state other than PARADO goes to PARADO on the next clk; actuators drop with the state; garrafas_parcial is held.
REQ-034 Priority: stop beats start, and both beat sensor events in the same cycle.
REQ-035 Sensor edges in states that do not consume them are ignored and not queued.
REQ-036 At most one bottle is in flight; there is no pipelining between stations.
REQ-037 The timer is 28 bits and is shared by ENCHENDO and VEDANDO; it is cleared on every state entry.

Reset
REQ-038 On reset_n=0, asynchronously: state=PARADO, all outputs 0, garrafas_parcial=0, timer=0, sensor edge registers=0.
REQ-039 The first clk after reset_n deasserts performs no transition unless start=1.

Verification (T_VEDACAO=4, T_ENCHE=20)
REQ-040 Nominal bottle: start, then sensor_posicao rise, sensor_nivel=1, sensor_vedacao rise, rejeito=0, sensor_final rise -> states 1,2,3,4,5,1; vedador high for exactly 4 cycles; garrafas_parcial=1.
REQ-041 Dozen: 12 nominal bottles -> incrementar_duzia pulses once, coincident with garrafas_parcial 11->0; a 13th bottle gives garrafas_parcial=1.
REQ-042 Reject: rejeito=1 on the last VEDANDO cycle -> descarte 1-cycle pulse, state returns to ESTEIRA, garrafas_parcial unchanged.
REQ-043 Fill timeout: ENCHENDO with sensor_nivel=0 -> ALARME after 20 cycles, valvula=0, alarme=1; start with rolhas_vazio=0 -> ESTEIRA plus a reset_contador pulse.
REQ-044 Caps empty: rolhas_vazio=1 at sensor_vedacao rise -> ALARME; start is ignored while rolhas_vazio=1.
REQ-045 Stop and reset:
  - stop asserted with start in the same cycle during ENCHENDO -> PARADO, valvula=0.
  - reset_n low mid-VEDANDO -> all outputs 0 immediately, without waiting for clk.
